// File: rtl/ffn_layer_sequencer_pkg.sv
// ffn_layer_sequencer_pkg: shared defaults and FSM state encoding for the FFN layer sequencer
package ffn_layer_sequencer_pkg;
  localparam int FFN_NUM_TILES = 4;
  localparam int FFN_MEM_LATENCY = 1;
  localparam int FFN_DP_LATENCY = 4;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ISSUE, SEQ_DRAIN, SEQ_DONE} seq_state_t;
endpackage

// File: rtl/ffn_layer_sequencer_if.sv
// ffn_layer_sequencer_if: job handshake, weight-read and result-write strobes of the sequencer
interface ffn_layer_sequencer_if #(parameter int TILE_AW = 2) ();
  logic [TILE_AW:0] cfg_num_tiles;
  logic in_valid;
  logic in_ready;
  logic in_load;
  logic w_rd_en;
  logic [TILE_AW-1:0] w_rd_addr;
  logic res_wr_en;
  logic [TILE_AW-1:0] res_wr_addr;
  logic out_valid;
  logic out_ready;
  logic busy;
  modport master (
    input cfg_num_tiles, in_valid, out_ready,
    output in_ready, in_load, w_rd_en, w_rd_addr, res_wr_en, res_wr_addr, out_valid, busy
  );
  modport slave (
    output cfg_num_tiles, in_valid, out_ready,
    input in_ready, in_load, w_rd_en, w_rd_addr, res_wr_en, res_wr_addr, out_valid, busy
  );
endinterface

// File: rtl/ffn_layer_sequencer_tag_pipe.sv
// ffn_tag_pipe: valid+address shift register that mirrors the memory and datapath latency
module ffn_tag_pipe #(
  parameter int DEPTH = 5,
  parameter int AW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [AW-1:0] push_addr,
  output logic tail_valid,
  output logic [AW-1:0] tail_addr,
  output logic any_valid
);
  logic [DEPTH-1:0] valid;
  logic [AW-1:0] addr [DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      valid <= '0;
      addr <= '{default: '0};
    end else begin
      valid[0] <= push;
      addr[0] <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid[i] <= valid[i-1];
        addr[i] <= addr[i-1];
      end
    end
  assign tail_valid = valid[DEPTH-1];
  assign tail_addr = addr[DEPTH-1];
  // Ignores the tail entry: set only while some tag will still be in flight next cycle
  assign any_valid = |(valid << 1);
endmodule

// File: rtl/ffn_layer_sequencer.sv
// ffn_layer_sequencer: job FSM, tile issue counter and result-write tracking for the FFN datapath
module ffn_layer_sequencer
  import ffn_layer_sequencer_pkg::*;
#(
  parameter int NUM_TILES = FFN_NUM_TILES,
  parameter int TILE_AW = $clog2(NUM_TILES),
  parameter int MEM_LATENCY = FFN_MEM_LATENCY,
  parameter int DP_LATENCY = FFN_DP_LATENCY
) (
  input logic clock,
  input logic reset,
  ffn_layer_sequencer_if.master bus
);
  typedef logic [TILE_AW:0] cnt_t;
  localparam cnt_t MAX_N = cnt_t'(NUM_TILES);
  seq_state_t state, state_nxt;
  cnt_t n, cnt, n_clamp;
  logic rdy, accept, pipe_v, pipe_any;
  logic [TILE_AW-1:0] pipe_addr;
  assign n_clamp = bus.cfg_num_tiles == '0 ? cnt_t'(1) : bus.cfg_num_tiles > MAX_N ? MAX_N : bus.cfg_num_tiles;
  ffn_tag_pipe #(.DEPTH(MEM_LATENCY + DP_LATENCY), .AW(TILE_AW)) tag_pipe (
    .clk(clock),
    .rst(reset),
    .push(bus.w_rd_en),
    .push_addr(bus.w_rd_addr),
    .tail_valid(pipe_v),
    .tail_addr(pipe_addr),
    .any_valid(pipe_any)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= SEQ_IDLE;
      n <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n <= n_clamp;
        cnt <= '0;
      end else if (state == SEQ_ISSUE) cnt <= cnt + 1'b1;
    end
  // Every strobe is forced low while reset is asserted so nothing leaks out mid-reset
  always_comb begin
    state_nxt = state;
    rdy = 1'b0;
    accept = 1'b0;
    bus.in_ready = 1'b0;
    bus.in_load = 1'b0;
    bus.w_rd_en = 1'b0;
    bus.w_rd_addr = '0;
    bus.res_wr_en = 1'b0;
    bus.res_wr_addr = '0;
    bus.out_valid = 1'b0;
    bus.busy = 1'b0;
    if (!reset) begin
      rdy = state == SEQ_IDLE;
      accept = rdy && bus.in_valid;
      bus.in_ready = rdy;
      bus.in_load = accept;
      bus.w_rd_en = state == SEQ_ISSUE;
      bus.w_rd_addr = cnt[TILE_AW-1:0];
      bus.res_wr_en = pipe_v;
      bus.res_wr_addr = pipe_addr;
      bus.out_valid = state == SEQ_DONE;
      bus.busy = state != SEQ_IDLE;
      unique case (state)
        SEQ_IDLE: state_nxt = accept ? SEQ_ISSUE : SEQ_IDLE;
        SEQ_ISSUE: state_nxt = cnt == n - 1'b1 ? SEQ_DRAIN : SEQ_ISSUE;
        SEQ_DRAIN: state_nxt = pipe_any ? SEQ_DRAIN : SEQ_DONE;
        SEQ_DONE: state_nxt = bus.out_ready ? SEQ_IDLE : SEQ_DONE;
        default: state_nxt = SEQ_IDLE;
      endcase
    end
  end
endmodule
